pipe_hazard_scoreboard: RTL and testbench

- Parametrised hazard-detection and forwarding unit for the in-order MIPS pipeline.
- Replaces the hand-written ForwardA/B/D/E and stall equations with a tracked destination-register pipeline of DEPTH post-ID stages.
- Produces forwarding selects for the ID-stage consumer (branch/jr compare) and the EX-stage consumer (ALU), plus the stall request.
- Adds saturating performance counters for stall cycles.

---
 rtl/pipe_pkg.sv | 29 ++
 rtl/sb_match.sv | 31 +++
 rtl/pipe_hazard_scoreboard.sv | 91 +++++++++
 tb/tb_pipe_hazard_scoreboard.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types, stage numbers and stall helper for the hazard scoreboard
package pipe_pkg;
  localparam int MAX_DEPTH = 7;
  localparam int SEL_W = $clog2(MAX_DEPTH + 1);
  localparam int SB_AW = 5;

  localparam int ST_EX = 1;
  localparam int ST_MEM = 2;
  localparam int ST_WB = 3;

  typedef struct packed {
    logic v;
    logic wr;
    logic ld;
    logic [SB_AW-1:0] rd;
    logic [SB_AW-1:0] rs;
    logic [SB_AW-1:0] rt;
    logic use_rs;
    logic use_rt;
  } sb_entry_t;

  // A branch needs the value now; an ALU consumer only needs it one stage later.
  function automatic logic src_blocks(logic [SEL_W-1:0] j, logic rdy, logic ld, logic br,
                                      int rdy_alu, int rdy_ld);
    if (j == '0) return 1'b0;
    if (br) return !rdy;
    return (int'(j) + 1) < (ld ? rdy_ld : rdy_alu);
  endfunction
endpackage

// File: rtl/sb_match.sv
// rtl/sb_match.sv - youngest-producer search for one consumer source operand
module sb_match import pipe_pkg::*; #(
  parameter int DEPTH = ST_WB,
  parameter int MIN_K = ST_EX,
  parameter int RDY_ALU = ST_MEM,
  parameter int RDY_LD = ST_WB
) (
  input  sb_entry_t [DEPTH:1] ent,
  input  logic [SB_AW-1:0]    addr,
  input  logic                use_src,
  output logic [SEL_W-1:0]    idx,
  output logic                ready,
  output logic                ld
);
  logic unused_ent;

  // Scan oldest to youngest so the youngest match is the one left standing.
  always_comb begin
    idx = '0;
    ld = 1'b0;
    for (int k = DEPTH; k >= MIN_K; k--) begin
      if (use_src && addr != '0 && ent[k].v && ent[k].wr && ent[k].rd == addr) begin
        idx = SEL_W'(k);
        ld = ent[k].ld;
      end
    end
  end

  assign ready = (idx != '0) && (int'(idx) >= (ld ? RDY_LD : RDY_ALU));
  assign unused_ent = ^ent;
endmodule

// File: rtl/pipe_hazard_scoreboard.sv
// rtl/pipe_hazard_scoreboard.sv - destination tracking, forwarding selects, stall and stall counters
module pipe_hazard_scoreboard import pipe_pkg::*; #(
  parameter int REG_AW = 5,
  parameter int DEPTH = ST_WB,
  parameter int RDY_ALU = ST_MEM,
  parameter int RDY_LD = ST_WB,
  parameter int CNT_W = 32
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic              id_br,
  input  logic              id_wr,
  input  logic              id_ld,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              cnt_clr,
  output logic              stall,
  output logic [2:0]        fwd_id_a,
  output logic [2:0]        fwd_id_b,
  output logic [2:0]        fwd_ex_a,
  output logic [2:0]        fwd_ex_b,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  ld_stall_cnt
);
  sb_entry_t [DEPTH:1] e_q, e_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, ld_stall_cnt_q, ld_stall_cnt_d;
  logic [SEL_W-1:0] id_a_idx, id_b_idx, ex_a_idx, ex_b_idx;
  logic id_a_rdy, id_b_rdy, id_a_ld, id_b_ld;
  logic ex_a_rdy_unused, ex_b_rdy_unused, ex_a_ld_unused, ex_b_ld_unused;
  logic blk_a, blk_b, ld_block;

  sb_match #(.DEPTH(DEPTH), .MIN_K(ST_EX), .RDY_ALU(RDY_ALU), .RDY_LD(RDY_LD)) u_id_a (
    .ent(e_q), .addr(SB_AW'(id_rs)), .use_src(id_use_rs),
    .idx(id_a_idx), .ready(id_a_rdy), .ld(id_a_ld));
  sb_match #(.DEPTH(DEPTH), .MIN_K(ST_EX), .RDY_ALU(RDY_ALU), .RDY_LD(RDY_LD)) u_id_b (
    .ent(e_q), .addr(SB_AW'(id_rt)), .use_src(id_use_rt),
    .idx(id_b_idx), .ready(id_b_rdy), .ld(id_b_ld));
  sb_match #(.DEPTH(DEPTH), .MIN_K(ST_MEM), .RDY_ALU(RDY_ALU), .RDY_LD(RDY_LD)) u_ex_a (
    .ent(e_q), .addr(e_q[1].rs), .use_src(e_q[1].use_rs),
    .idx(ex_a_idx), .ready(ex_a_rdy_unused), .ld(ex_a_ld_unused));
  sb_match #(.DEPTH(DEPTH), .MIN_K(ST_MEM), .RDY_ALU(RDY_ALU), .RDY_LD(RDY_LD)) u_ex_b (
    .ent(e_q), .addr(e_q[1].rt), .use_src(e_q[1].use_rt),
    .idx(ex_b_idx), .ready(ex_b_rdy_unused), .ld(ex_b_ld_unused));

  assign blk_a = src_blocks(id_a_idx, id_a_rdy, id_a_ld, id_br, RDY_ALU, RDY_LD);
  assign blk_b = src_blocks(id_b_idx, id_b_rdy, id_b_ld, id_br, RDY_ALU, RDY_LD);
  assign stall = id_valid && (blk_a || blk_b);
  assign ld_block = id_valid && ((blk_a && id_a_ld) || (blk_b && id_b_ld));

  assign fwd_id_a = (id_br && id_a_rdy) ? 3'(id_a_idx) : 3'd0;
  assign fwd_id_b = (id_br && id_b_rdy) ? 3'(id_b_idx) : 3'd0;
  // The EX consumer was only allowed to issue once its producer would be ready here.
  assign fwd_ex_a = e_q[1].v ? 3'(ex_a_idx) : 3'd0;
  assign fwd_ex_b = e_q[1].v ? 3'(ex_b_idx) : 3'd0;

  assign stall_cnt = stall_cnt_q;
  assign ld_stall_cnt = ld_stall_cnt_q;

  always_comb begin
    e_d = e_q;
    for (int k = DEPTH; k >= 2; k--) e_d[k] = e_q[k-1];
    e_d[1] = '{v: id_valid && !stall, wr: id_wr, ld: id_ld, rd: SB_AW'(id_rd),
               rs: SB_AW'(id_rs), rt: SB_AW'(id_rt), use_rs: id_use_rs, use_rt: id_use_rt};

    stall_cnt_d = stall_cnt_q;
    ld_stall_cnt_d = ld_stall_cnt_q;
    if (cnt_clr) begin
      stall_cnt_d = '0;
      ld_stall_cnt_d = '0;
    end else begin
      if (stall && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
      if (ld_block && !(&ld_stall_cnt_q)) ld_stall_cnt_d = ld_stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      e_q <= '0;
      stall_cnt_q <= '0;
      ld_stall_cnt_q <= '0;
    end else begin
      e_q <= e_d;
      stall_cnt_q <= stall_cnt_d;
      ld_stall_cnt_q <= ld_stall_cnt_d;
    end
  end
endmodule

// File: tb/tb_pipe_hazard_scoreboard.sv
// tb/tb_pipe_hazard_scoreboard.sv - directed vectors, corner sequences and randomized model comparison
module tb_pipe_hazard_scoreboard;
  localparam int DEPTH = 3;
  localparam int RDY_ALU = 2;
  localparam int RDY_LD = 3;
  localparam int CNT_W = 6;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic Clk = 1'b0;
  logic Rst = 1'b1;
  logic id_valid = 1'b0;
  logic [4:0] id_rs = '0, id_rt = '0, id_rd = '0;
  logic id_use_rs = 1'b0, id_use_rt = 1'b0, id_br = 1'b0, id_wr = 1'b0, id_ld = 1'b0;
  logic cnt_clr = 1'b0;
  logic stall;
  logic [2:0] fwd_id_a, fwd_id_b, fwd_ex_a, fwd_ex_b;
  logic [CNT_W-1:0] stall_cnt, ld_stall_cnt;

  int checks = 0;
  int errors = 0;

  pipe_hazard_scoreboard #(.REG_AW(5), .DEPTH(DEPTH), .RDY_ALU(RDY_ALU), .RDY_LD(RDY_LD),
                           .CNT_W(CNT_W)) dut (
    .Clk(Clk), .Rst(Rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_br(id_br), .id_wr(id_wr),
    .id_ld(id_ld), .id_rd(id_rd), .cnt_clr(cnt_clr), .stall(stall),
    .fwd_id_a(fwd_id_a), .fwd_id_b(fwd_id_b), .fwd_ex_a(fwd_ex_a), .fwd_ex_b(fwd_ex_b),
    .stall_cnt(stall_cnt), .ld_stall_cnt(ld_stall_cnt));

  always #5 Clk = ~Clk;

  typedef struct {
    bit valid;
    int rs, rt;
    bit urs, urt, br, wr, ld;
    int rd;
  } ins_t;

  typedef struct {
    ins_t i;
    bit st;
    int fia, fib, fea, feb, sc, lsc;
  } vec_t;

  function automatic ins_t mk(bit valid, int rs, int rt, bit urs, bit urt, bit br, bit wr,
                              bit ld, int rd);
    ins_t r;
    r.valid = valid; r.rs = rs; r.rt = rt; r.urs = urs; r.urt = urt;
    r.br = br; r.wr = wr; r.ld = ld; r.rd = rd;
    return r;
  endfunction

  function automatic ins_t alu(int rd, int rs, int rt); return mk(1, rs, rt, 1, 1, 0, 1, 0, rd); endfunction
  function automatic ins_t lw(int rd, int rs); return mk(1, rs, 0, 1, 0, 0, 1, 1, rd); endfunction
  function automatic ins_t beq(int rs, int rt); return mk(1, rs, rt, 1, 1, 1, 0, 0, 0); endfunction
  function automatic ins_t nop(); return mk(0, 0, 0, 0, 0, 0, 0, 0, 0); endfunction

  function automatic vec_t row(ins_t i, bit st, int fia, int fib, int fea, int feb, int sc, int lsc);
    vec_t v;
    v.i = i; v.st = st; v.fia = fia; v.fib = fib; v.fea = fea; v.feb = feb; v.sc = sc; v.lsc = lsc;
    return v;
  endfunction

  task automatic drive(ins_t i);
    id_valid = i.valid; id_rs = 5'(i.rs); id_rt = 5'(i.rt); id_use_rs = i.urs;
    id_use_rt = i.urt; id_br = i.br; id_wr = i.wr; id_ld = i.ld; id_rd = 5'(i.rd);
  endtask

  task automatic chk(string tag, string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s %s: got %0d expected %0d", tag, nm, act, exp);
    end
  endtask

  task automatic chk_all(string tag, bit st, int fia, int fib, int fea, int feb, int sc, int lsc);
    chk(tag, "stall", int'(stall), int'(st));
    chk(tag, "fwd_id_a", int'(fwd_id_a), fia);
    chk(tag, "fwd_id_b", int'(fwd_id_b), fib);
    chk(tag, "fwd_ex_a", int'(fwd_ex_a), fea);
    chk(tag, "fwd_ex_b", int'(fwd_ex_b), feb);
    chk(tag, "stall_cnt", int'(stall_cnt), sc);
    chk(tag, "ld_stall_cnt", int'(ld_stall_cnt), lsc);
  endtask

  // Present an instruction and hold it until it is accepted (bounded).
  task automatic issue(ins_t i);
    bit done;
    done = 0;
    @(posedge Clk); #1;
    drive(i);
    for (int n = 0; n < 8 && !done; n++) begin
      @(negedge Clk);
      if (!stall) done = 1;
      else begin
        @(posedge Clk); #1;
      end
    end
    if (!done) chk("issue", "timeout", 1, 0);
  endtask

  // Reference pipeline: element 0 is the EX stage, element k-1 is stage k.
  ins_t mq[$];

  function automatic int youngest(int s, int lo);
    for (int k = lo; k <= DEPTH; k++)
      if (s != 0 && mq[k-1].valid && mq[k-1].wr && mq[k-1].rd == s) return k;
    return 0;
  endfunction

  function automatic int need(int j);
    return mq[j-1].ld ? RDY_LD : RDY_ALU;
  endfunction

  vec_t tbl[27];
  ins_t cur, ent;
  bit hold, r, clr, mst, mldb, blk_a, blk_b;
  int ja, jb, msc, mlsc, mfia, mfib, mfea, mfeb;

  initial begin
    tbl[0]  = row(alu(3, 1, 2),  0, 0, 0, 0, 0, 0, 0);
    tbl[1]  = row(alu(9, 3, 1),  0, 0, 0, 0, 0, 0, 0);
    tbl[2]  = row(nop(),         0, 0, 0, 2, 0, 0, 0);
    tbl[3]  = row(alu(3, 1, 2),  0, 0, 0, 0, 0, 0, 0);
    tbl[4]  = row(nop(),         0, 0, 0, 0, 0, 0, 0);
    tbl[5]  = row(alu(10, 3, 2), 0, 0, 0, 0, 0, 0, 0);
    tbl[6]  = row(nop(),         0, 0, 0, 3, 0, 0, 0);
    tbl[7]  = row(lw(4, 1),      0, 0, 0, 0, 0, 0, 0);
    tbl[8]  = row(alu(11, 2, 4), 1, 0, 0, 0, 0, 0, 0);
    tbl[9]  = row(alu(11, 2, 4), 0, 0, 0, 0, 0, 1, 1);
    tbl[10] = row(nop(),         0, 0, 0, 0, 3, 1, 1);
    tbl[11] = row(alu(5, 1, 2),  0, 0, 0, 0, 0, 1, 1);
    tbl[12] = row(beq(5, 0),     1, 0, 0, 0, 0, 1, 1);
    tbl[13] = row(beq(5, 0),     0, 2, 0, 0, 0, 2, 1);
    tbl[14] = row(lw(5, 1),      0, 0, 0, 3, 0, 2, 1);
    tbl[15] = row(beq(5, 0),     1, 0, 0, 0, 0, 2, 1);
    tbl[16] = row(beq(5, 0),     1, 0, 0, 0, 0, 3, 2);
    tbl[17] = row(beq(5, 0),     0, 3, 0, 0, 0, 4, 3);
    tbl[18] = row(alu(6, 1, 2),  0, 0, 0, 0, 0, 4, 3);
    tbl[19] = row(lw(6, 1),      0, 0, 0, 0, 0, 4, 3);
    tbl[20] = row(alu(12, 6, 6), 1, 0, 0, 0, 0, 4, 3);
    tbl[21] = row(alu(12, 6, 6), 0, 0, 0, 0, 0, 5, 4);
    tbl[22] = row(nop(),         0, 0, 0, 3, 3, 5, 4);
    tbl[23] = row(lw(0, 1),      0, 0, 0, 0, 0, 5, 4);
    tbl[24] = row(beq(0, 0),     0, 0, 0, 0, 0, 5, 4);
    tbl[25] = row(alu(13, 0, 0), 0, 0, 0, 0, 0, 5, 4);
    tbl[26] = row(nop(),         0, 0, 0, 0, 0, 5, 4);

    drive(nop());
    repeat (2) @(posedge Clk);
    #1 Rst = 1'b0;

    for (int n = 0; n < 27; n++) begin
      @(posedge Clk); #1;
      drive(tbl[n].i);
      @(negedge Clk);
      chk_all($sformatf("vec%0d", n), tbl[n].st, tbl[n].fia, tbl[n].fib, tbl[n].fea,
              tbl[n].feb, tbl[n].sc, tbl[n].lsc);
    end

    // Counter accumulation and saturation: each lw/beq pair costs two load stalls.
    cnt_clr = 1'b1;
    issue(nop());
    cnt_clr = 1'b0;
    for (int n = 0; n < 10; n++) begin
      issue(lw(4, 1));
      issue(beq(4, 0));
    end
    chk("sat", "stall_cnt_20", int'(stall_cnt), 20);
    chk("sat", "ld_stall_cnt_20", int'(ld_stall_cnt), 20);
    for (int n = 0; n < 30; n++) begin
      issue(lw(4, 1));
      issue(beq(4, 0));
    end
    chk("sat", "stall_cnt_max", int'(stall_cnt), CNT_MAX);
    chk("sat", "ld_stall_cnt_max", int'(ld_stall_cnt), CNT_MAX);

    // Clear wins over an increment in the same cycle.
    issue(lw(4, 1));
    @(posedge Clk); #1;
    drive(beq(4, 0));
    cnt_clr = 1'b1;
    @(negedge Clk);
    chk("clr", "stall_first", int'(stall), 1);
    @(posedge Clk); #1;
    cnt_clr = 1'b0;
    @(negedge Clk);
    chk_all("clr_next", 1, 0, 0, 0, 0, 0, 0);
    @(posedge Clk); #1;
    @(negedge Clk);
    chk_all("clr_after", 0, 3, 0, 0, 0, 1, 1);

    // Reset in the middle of a load-use stall.
    issue(lw(4, 1));
    @(posedge Clk); #1;
    drive(alu(11, 2, 4));
    @(negedge Clk);
    chk("rst", "stall_before", int'(stall), 1);
    Rst = 1'b1;
    @(posedge Clk); #1;
    Rst = 1'b0;
    drive(beq(4, 4));
    @(negedge Clk);
    chk_all("rst_after", 0, 0, 0, 0, 0, 0, 0);
    @(posedge Clk); #1;
    drive(alu(12, 4, 4));
    @(negedge Clk);
    chk_all("rst_next", 0, 0, 0, 0, 0, 0, 0);

    // Randomized run against the reference pipeline.
    mq = {};
    repeat (DEPTH) mq.push_back(nop());
    msc = 0; mlsc = 0; hold = 0;
    for (int c = 0; c < 1500; c++) begin
      @(posedge Clk); #1;
      if (!hold) begin
        cur.valid = $urandom_range(0, 9) != 0;
        cur.rs = $urandom_range(0, 5);
        cur.rt = $urandom_range(0, 5);
        cur.urs = $urandom_range(0, 7) != 0;
        cur.urt = $urandom_range(0, 1) != 0;
        cur.br = $urandom_range(0, 4) == 0;
        cur.ld = !cur.br && ($urandom_range(0, 3) == 0);
        cur.wr = !cur.br && ($urandom_range(0, 9) != 0);
        cur.rd = $urandom_range(0, 5);
      end
      r = (c == 0) || ($urandom_range(0, 63) == 0);
      clr = $urandom_range(0, 31) == 0;
      Rst = r;
      cnt_clr = clr;
      drive(cur);
      @(negedge Clk);

      ja = cur.urs ? youngest(cur.rs, 1) : 0;
      jb = cur.urt ? youngest(cur.rt, 1) : 0;
      blk_a = ja != 0 && (cur.br ? ja < need(ja) : ja + 1 < need(ja));
      blk_b = jb != 0 && (cur.br ? jb < need(jb) : jb + 1 < need(jb));
      mfia = (cur.br && ja != 0 && ja >= need(ja)) ? ja : 0;
      mfib = (cur.br && jb != 0 && jb >= need(jb)) ? jb : 0;
      mst = cur.valid && (blk_a || blk_b);
      mldb = cur.valid && ((blk_a && mq[ja > 0 ? ja - 1 : 0].ld) ||
                           (blk_b && mq[jb > 0 ? jb - 1 : 0].ld));
      mfea = (mq[0].valid && mq[0].urs) ? youngest(mq[0].rs, 2) : 0;
      mfeb = (mq[0].valid && mq[0].urt) ? youngest(mq[0].rt, 2) : 0;
      chk_all($sformatf("rnd%0d", c), mst, mfia, mfib, mfea, mfeb, msc, mlsc);

      if (r) begin
        foreach (mq[k]) mq[k].valid = 0;
        msc = 0;
        mlsc = 0;
      end else begin
        if (clr) begin
          msc = 0;
          mlsc = 0;
        end else begin
          if (mst && msc < CNT_MAX) msc++;
          if (mldb && mlsc < CNT_MAX) mlsc++;
        end
        ent = cur;
        ent.valid = cur.valid && !mst;
        mq.push_front(ent);
        void'(mq.pop_back());
      end
      hold = mst;
    end
    Rst = 1'b0;
    cnt_clr = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
